chu_spi_core: RTL and testbench
===============================

Name: chu_spi_core

Overview:
- MMIO slot core on the FPro bus, downstream of the MicroBlaze MCS bridge through the MMIO controller's slot decode.
- Implements a byte-oriented SPI master: software writes slave-select, mode and divider registers, then a data register that starts an 8-bit full-duplex transfer.
- Software polls a ready bit and reads back the received byte.

Parameters:
- S, 2, number of active-low slave-select outputs (1..32).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cs  input  1  slot chip select from MMIO controller
- read  input  1  read strobe (qualified by cs)
- write  input  1  write strobe (qualified by cs)
- addr  input  5  word offset within slot
- wr_data  input  32  write data
- rd_data  output  32  read data
- spi_sclk  output  1  SPI serial clock
- spi_mosi  output  1  master out
- spi_miso  input  1  master in
- spi_ss_n  output  S  slave selects, active low

Behaviour:
- Register map, word offsets; only addr[1:0] decoded:
  - 0 (R): rd_data = {23'b0, ready, rx_byte[7:0]}.
  - 1 (W): ss_n_reg <= wr_data[S-1:0]; spi_ss_n = ss_n_reg directly, never touched by the FSM.
  - 2 (W): ctrl_reg <= {cpha = wr_data[17], cpol = wr_data[16], dvsr = wr_data[15:0]}.
  - 3 (W): tx byte = wr_data[7:0]; starts a transfer only if ready = 1, otherwise ignored.
- Read decode:
  - rd_data is combinational from addr; offsets 1–3 read as 0.
  - The read strobe has no side effects.
- Write qualification: a write takes effect on the clk edge where cs & write. Writes to offsets 1 and 2 are accepted at any time.
- Transfer start latching: dvsr, cpol and cpha are copied into working registers when a transfer starts. Writing offset 2 mid-transfer does not alter the transfer in progress.
- Reset values (asynchronous):
  - ss_n_reg all 1s; ctrl_reg 0; working copies 0.
  - rx_byte 0; tx shift 0; ready 1; state IDLE; divider counter 0.
  - Hence spi_sclk 0, spi_mosi 0, spi_ss_n all 1.
- Reset asserted mid-transfer aborts immediately to these values.
- Divider: each phase state lasts dvsr+1 clk cycles. Counter counts 0..dvsr (16-bit), then clears on state advance. dvsr = 0 gives a half-period of 1 clk.
- FSM states: IDLE, CPHA_DELAY, P0, P1.
  - IDLE: on an accepted data write, load the tx shift register, latch the working copies, set ready = 0 the next cycle, and clear the bit counter. Go to CPHA_DELAY if cpha = 1, else P0.
  - CPHA_DELAY: one half-period, sclk idle, then go to P0.
  - P0: at its end, sample spi_miso into the rx shift register (LSB in, shift left), then go to P1.
  - P1: at its end, shift tx left. If bit counter = 7, go to IDLE, set ready = 1, and copy the rx shift register to rx_byte. Otherwise increment the bit counter and go to P0.
- spi_mosi = tx_shift[7]; bits go out MSB first. In IDLE it holds the last shifted value (0 after a complete byte).
- Phase clock:
  - p_clk = (state == P1 & ~cpha) | (state == P0 & cpha).
  - spi_sclk = p_clk ^ cpol, registered-free combinational from state.
  - Idle level of spi_sclk equals the working cpol.
- Edge semantics:
  - Mode cpha = 0: sample on the leading edge, shift on the trailing edge.
  - Mode cpha = 1: the first bit is presented during CPHA_DELAY; sample on the trailing edge.
- Busy duration from the cycle after the data write until ready = 1:
  - 16·(dvsr+1) cycles for cpha = 0.
  - 17·(dvsr+1) cycles for cpha = 1.
- Back-to-back transfers: a data write in the same cycle ready rises is accepted.

Test Plan:
- Reset: assert reset mid-transfer → next cycle spi_ss_n = 2'b11, spi_sclk = 0, ready = 1, rx_byte = 0; read offset 0 returns 0x0000_0100.
- Mode 0 loopback: ctrl = 0x0000_0001 (dvsr = 1), ss = 2'b10, write 0xA5 with spi_miso tied to spi_mosi → exactly 8 sclk rising edges, ready low for 32 cycles, offset 0 reads 0x0000_01A5, spi_ss_n stays 2'b10 throughout.
- Mode 3: ctrl = 0x0003_0000 (cpol = 1, cpha = 1, dvsr = 0), slave model returns 0x3C → sclk idles 1, busy 17 cycles, rx_byte = 0x3C.
- Busy write ignored: write 0x11 then 0x22 while ready = 0 → MOSI shows 0x11 only; offset 2 written mid-transfer to dvsr = 7 leaves the current byte at the original rate and applies to the next byte.
- Max divider: dvsr = 0xFFFF → sclk half-period 65536 cycles, no counter wrap glitch, correct byte received.
- Address decode: reads of offsets 1–3 and writes with cs = 0 → rd_data = 0, no register changes.

Source files
------------

// File: rtl/chu_spi_core.sv
// chu_spi_core: byte-wide SPI master in an FPro MMIO slot.
// Software programs slave selects, mode and divider, then writes a byte to start a transfer.
module chu_spi_core #(
  parameter int S = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic          spi_sclk,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic [S-1:0]  spi_ss_n
);

  typedef enum logic [1:0] {
    IDLE,
    CPHA_DELAY,
    P0,
    P1
  } state_t;

  state_t       state_reg, state_next;
  logic [15:0]  c_reg, c_next;
  logic [2:0]   n_reg, n_next;
  logic [7:0]   tx_reg, tx_next;
  logic [7:0]   rx_reg, rx_next;
  logic [7:0]   rx_byte_reg, rx_byte_next;
  logic         ready_reg, ready_next;
  logic [15:0]  dvsr_reg, dvsr_next;
  logic         cpol_reg, cpol_next;
  logic         cpha_reg, cpha_next;
  logic [17:0]  ctrl_reg;
  logic [S-1:0] ss_n_reg;

  logic wr_ss, wr_ctrl, wr_tx, last, p_clk;
  logic unused;

  assign unused  = ^{read, addr[4:2], wr_data};
  assign wr_ss   = cs & write & (addr[1:0] == 2'd1);
  assign wr_ctrl = cs & write & (addr[1:0] == 2'd2);
  assign wr_tx   = cs & write & (addr[1:0] == 2'd3);
  assign last    = (c_reg == dvsr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_n_reg <= '1;
      ctrl_reg <= '0;
    end else begin
      if (wr_ss)
        ss_n_reg <= wr_data[S-1:0];
      if (wr_ctrl)
        ctrl_reg <= wr_data[17:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      c_reg       <= '0;
      n_reg       <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_byte_reg <= '0;
      ready_reg   <= 1'b1;
      dvsr_reg    <= '0;
      cpol_reg    <= 1'b0;
      cpha_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      c_reg       <= c_next;
      n_reg       <= n_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_byte_reg <= rx_byte_next;
      ready_reg   <= ready_next;
      dvsr_reg    <= dvsr_next;
      cpol_reg    <= cpol_next;
      cpha_reg    <= cpha_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    c_next       = c_reg;
    n_next       = n_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_byte_next = rx_byte_reg;
    ready_next   = ready_reg;
    dvsr_next    = dvsr_reg;
    cpol_next    = cpol_reg;
    cpha_next    = cpha_reg;
    unique case (state_reg)
      IDLE: begin
        if (wr_tx) begin
          tx_next    = wr_data[7:0];
          dvsr_next  = ctrl_reg[15:0];
          cpol_next  = ctrl_reg[16];
          cpha_next  = ctrl_reg[17];
          ready_next = 1'b0;
          n_next     = '0;
          c_next     = '0;
          state_next = ctrl_reg[17] ? CPHA_DELAY : P0;
        end
      end
      CPHA_DELAY: begin
        if (last) begin
          c_next     = '0;
          state_next = P0;
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      P0: begin
        if (last) begin
          rx_next    = {rx_reg[6:0], spi_miso};
          c_next     = '0;
          state_next = P1;
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      P1: begin
        if (last) begin
          tx_next = {tx_reg[6:0], 1'b0};
          c_next  = '0;
          if (n_reg == 3'd7) begin
            state_next   = IDLE;
            ready_next   = 1'b1;
            rx_byte_next = rx_reg;
          end else begin
            n_next     = n_reg + 3'd1;
            state_next = P0;
          end
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Phase clock is high in the second half-bit for cpha=0, the first for cpha=1
  assign p_clk = ((state_reg == P1) & ~cpha_reg) |
                 ((state_reg == P0) & cpha_reg);

  assign spi_sclk = p_clk ^ cpol_reg;
  assign spi_mosi = tx_reg[7];
  assign spi_ss_n = ss_n_reg;
  assign rd_data  = (addr[1:0] == 2'd0) ?
                    {23'b0, ready_reg, rx_byte_reg} : 32'b0;

endmodule

// File: tb/tb_chu_spi_core.sv
// tb_chu_spi_core: register-decode vector table plus scoreboarded SPI transfers.
// Slave model shifts a byte out MSB first, advancing on each rising sclk.
module tb_chu_spi_core;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs, read, write;
  logic [4:0]   addr;
  logic [31:0]  wr_data, rd_data;
  logic         spi_sclk, spi_mosi, spi_miso;
  logic [S-1:0] spi_ss_n;

  chu_spi_core #(.S(S)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_ss_n(spi_ss_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         loop = 1'b0;
  logic         mon_en = 1'b0;
  logic         mon_ss = 1'b0;
  logic [7:0]   slv_byte = 8'h00;
  logic [7:0]   cap = 8'h00;
  logic [2:0]   slv_idx = 3'd7;
  int           rises = 0;
  int           ss_bad = 0;
  logic [S-1:0] ss_exp = '1;
  logic [7:0]   exp_q[$];

  assign spi_miso = loop ? spi_mosi : slv_byte[slv_idx];

  always @(posedge spi_sclk)
    if (mon_en) begin
      cap = {cap[6:0], spi_mosi};
      rises++;
      slv_idx--;
    end

  always @(negedge clk)
    if (mon_ss && spi_ss_n !== ss_exp) ss_bad++;

  typedef struct {
    logic        c;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] erd;
    logic [1:0]  ess;
  } vec_t;

  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic c, input logic w, input logic [4:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    cs = c; write = w; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; cs = 1'b1; read = 1'b1;
    #1 d = rd_data;
    cs = 1'b0; read = 1'b0; addr = 5'd0;
  endtask

  task automatic wait_ready(input int t0, input int budget, output int busy);
    int k;
    k = 0;
    addr = 5'd0;
    #1;
    while (!rd_data[8] && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("ready_seen", {31'b0, rd_data[8]}, 32'd1);
    busy = cyc - t0;
  endtask

  task automatic sb_pop(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    check({name, "_sbdepth"}, exp_q.size(), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    rd(5'd0, d);
    check(name, d, {23'b0, 1'b1, e});
  endtask

  initial begin
    logic [31:0] d;
    int t0, busy, k;

    tv[0] = '{1'b1, 1'b1, 5'd1,  32'h0000_0002, 5'd1,  32'h0000_0000, 2'b10};
    tv[1] = '{1'b0, 1'b1, 5'd1,  32'h0000_0001, 5'd0,  32'h0000_0100, 2'b10};
    tv[2] = '{1'b0, 1'b1, 5'd3,  32'h0000_00FF, 5'd0,  32'h0000_0100, 2'b10};
    tv[3] = '{1'b1, 1'b1, 5'd2,  32'h0000_0001, 5'd2,  32'h0000_0000, 2'b10};
    tv[4] = '{1'b1, 1'b1, 5'd1,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 2'b11};
    tv[5] = '{1'b1, 1'b1, 5'd5,  32'h0000_0000, 5'd29, 32'h0000_0000, 2'b00};
    tv[6] = '{1'b1, 1'b1, 5'd17, 32'h0000_0003, 5'd28, 32'h0000_0100, 2'b11};
    tv[7] = '{1'b1, 1'b0, 5'd1,  32'h0000_0000, 5'd0,  32'h0000_0100, 2'b11};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = 5'd0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(5'd0, d);
    check("rst_rd0", d, 32'h0000_0100);
    check("rst_ss", {30'b0, spi_ss_n}, 32'h3);
    check("rst_sclk", {31'b0, spi_sclk}, 32'h0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      bus_wr(tv[i].c, tv[i].w, tv[i].wa, tv[i].wd);
      rd(tv[i].ra, d);
      check($sformatf("vec%0d_rd", i), d, tv[i].erd);
      check($sformatf("vec%0d_ss", i), {30'b0, spi_ss_n}, {30'b0, tv[i].ess});
      check($sformatf("vec%0d_sclk", i), {31'b0, spi_sclk}, 32'h0);
    end

    // Mode 0 loopback
    bus_wr(1'b1, 1'b1, 5'd2, 32'h0000_0001);
    bus_wr(1'b1, 1'b1, 5'd1, 32'h0000_0002);
    ss_exp = 2'b10; ss_bad = 0; mon_ss = 1'b1;
    loop = 1'b1; rises = 0; cap = 8'h00;
    exp_q.push_back(8'hA5);
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_00A5);
    t0 = cyc; mon_en = 1'b1;
    wait_ready(t0, 100, busy);
    mon_en = 1'b0;
    check("m0_busy", busy, 32);
    check("m0_rises", rises, 8);
    check("m0_mosi_cap", {24'b0, cap}, 32'hA5);
    check("m0_mosi_end", {31'b0, spi_mosi}, 32'h0);
    sb_pop("m0_rx");
    mon_ss = 1'b0;
    check("m0_ss_hold", ss_bad, 0);

    // Mode 3 with slave returning 0x3C
    bus_wr(1'b1, 1'b1, 5'd2, 32'h0003_0000);
    loop = 1'b0; slv_byte = 8'h3C; slv_idx = 3'd7;
    rises = 0; cap = 8'h00;
    exp_q.push_back(8'h3C);
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_0096);
    t0 = cyc; mon_en = 1'b1;
    check("m3_sclk_delay", {31'b0, spi_sclk}, 32'h1);
    wait_ready(t0, 100, busy);
    mon_en = 1'b0;
    check("m3_busy", busy, 17);
    check("m3_rises", rises, 8);
    check("m3_mosi_cap", {24'b0, cap}, 32'h96);
    check("m3_sclk_idle", {31'b0, spi_sclk}, 32'h1);
    sb_pop("m3_rx");

    // Writes while busy: data ignored, ctrl applies to next byte
    bus_wr(1'b1, 1'b1, 5'd2, 32'h0000_0001);
    loop = 1'b1; rises = 0; cap = 8'h00;
    exp_q.push_back(8'h11);
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_0011);
    t0 = cyc; mon_en = 1'b1;
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_0022);
    bus_wr(1'b1, 1'b1, 5'd2, 32'h0000_0007);
    wait_ready(t0, 200, busy);
    mon_en = 1'b0;
    check("bz_busy1", busy, 32);
    check("bz_rises1", rises, 8);
    check("bz_cap1", {24'b0, cap}, 32'h11);
    sb_pop("bz_rx1");
    rises = 0; cap = 8'h00;
    exp_q.push_back(8'h33);
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_0033);
    t0 = cyc; mon_en = 1'b1;
    wait_ready(t0, 300, busy);
    mon_en = 1'b0;
    check("bz_busy2", busy, 128);
    check("bz_cap2", {24'b0, cap}, 32'h33);
    sb_pop("bz_rx2");

    // Max divider first half-period, then reset mid-transfer
    bus_wr(1'b1, 1'b1, 5'd2, 32'h0000_FFFF);
    bus_wr(1'b1, 1'b1, 5'd3, 32'h0000_005A);
    k = 0;
    #1;
    while (spi_sclk == 1'b0 && k < 70000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("maxdiv_half", k, 65536);
    check("maxdiv_sclk", {31'b0, spi_sclk}, 32'h1);
    rd(5'd0, d);
    check("maxdiv_busy_rd", d, 32'h0000_0033);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_ss", {30'b0, spi_ss_n}, 32'h3);
    check("arst_sclk", {31'b0, spi_sclk}, 32'h0);
    check("arst_mosi", {31'b0, spi_mosi}, 32'h0);
    rd(5'd0, d);
    check("arst_rd0", d, 32'h0000_0100);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rd(5'd0, d);
    check("post_rst_rd0", d, 32'h0000_0100);
    check("post_rst_sclk", {31'b0, spi_sclk}, 32'h0);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
